// File: rtl/run_ctrl.sv
// Run controller: sequences a core through reset, run and completion, with a
// RUN-cycle budget that forces a timeout when the program never halts.
module run_ctrl #(
  parameter int unsigned IW      = 8,
  parameter int unsigned CW      = 16,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned MAX_CYC = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] start_addr,
  input  logic          halt_i,
  input  logic          abort,
  output logic          core_reset,
  output logic          core_en,
  output logic [IW-1:0] pc_init,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  localparam logic [3:0]    RstCyc = 4'(RST_CYC);
  localparam logic [CW-1:0] MaxCyc = CW'(MAX_CYC);

  state_e        state_q, state_d;
  logic [3:0]    init_cnt_q, init_cnt_d;
  logic [IW-1:0] pc_init_q, pc_init_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic [CW-1:0] cycle_inc;
  logic          timeout_q, timeout_d;

  // Next-state and datapath updates; every register holds unless a rule fires.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    pc_init_d     = pc_init_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    cycle_inc     = cycle_count_q + CW'(1);

    unique case (state_q)
      // DONE restarts exactly like IDLE; abort and halt_i are ignored here.
      StIdle, StDone: begin
        if (start) begin
          state_d       = StInit;
          pc_init_d     = start_addr;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          init_cnt_d    = RstCyc;
        end
      end
      StInit: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          init_cnt_d = init_cnt_q - 4'd1;
          if (init_cnt_d == 4'd0) begin
            state_d = StRun;
          end
        end
      end
      // The exit cycle (abort, halt or budget) is still counted as a RUN cycle.
      StRun: begin
        cycle_count_d = cycle_inc;
        if (abort) begin
          state_d = StIdle;
        end else if (halt_i) begin
          state_d = StDone;
        end else if (cycle_inc == MaxCyc) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      init_cnt_q    <= 4'd0;
      pc_init_q     <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      pc_init_q     <= pc_init_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    core_reset  = (state_q == StIdle) || (state_q == StInit);
    core_en     = (state_q == StRun);
    busy        = (state_q == StInit) || (state_q == StRun);
    done        = (state_q == StDone);
    timeout     = timeout_q;
    pc_init     = pc_init_q;
    cycle_count = cycle_count_q;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus random traffic, every cycle
// compared against a phase-level reference model.
module tb_run_ctrl;

  localparam int IW      = 8;
  localparam int CW      = 16;
  localparam int RST_CYC = 2;
  localparam int MAX_CYC = 20;

  localparam int PIdle = 0;
  localparam int PInit = 1;
  localparam int PRun  = 2;
  localparam int PDone = 3;

  logic          clk = 1'b0;
  logic          reset, start, halt_i, abort;
  logic [IW-1:0] start_addr;
  logic          core_reset, core_en, busy, done, timeout;
  logic [IW-1:0] pc_init;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_phase     = PIdle;
  int m_init_done = 0;
  int m_cnt       = 0;
  int m_pc        = 0;
  bit m_to        = 1'b0;

  run_ctrl #(
    .IW     (IW),
    .CW     (CW),
    .RST_CYC(RST_CYC),
    .MAX_CYC(MAX_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .halt_i     (halt_i),
    .abort      (abort),
    .core_reset (core_reset),
    .core_en    (core_en),
    .pc_init    (pc_init),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (reset) begin
      m_phase = PIdle; m_init_done = 0; m_cnt = 0; m_pc = 0; m_to = 1'b0;
    end else begin
      case (m_phase)
        PIdle, PDone: if (start) begin
          m_phase = PInit; m_pc = int'(start_addr); m_cnt = 0; m_to = 1'b0; m_init_done = 0;
        end
        PInit: if (abort) m_phase = PIdle;
               else begin
                 m_init_done++;
                 if (m_init_done == RST_CYC) m_phase = PRun;
               end
        PRun: begin
          m_cnt++;
          if (abort) m_phase = PIdle;
          else if (halt_i) m_phase = PDone;
          else if (m_cnt == MAX_CYC) begin
            m_phase = PDone; m_to = 1'b1;
          end
        end
        default: m_phase = PIdle;
      endcase
    end
  endtask

  task automatic check_model();
    check_eq("m_core_reset", 32'(core_reset), 32'(m_phase == PIdle || m_phase == PInit));
    check_eq("m_core_en", 32'(core_en), 32'(m_phase == PRun));
    check_eq("m_busy", 32'(busy), 32'(m_phase == PInit || m_phase == PRun));
    check_eq("m_done", 32'(done), 32'(m_phase == PDone));
    check_eq("m_timeout", 32'(timeout), 32'(m_to));
    check_eq("m_pc_init", 32'(pc_init), 32'(m_pc));
    check_eq("m_cycle_count", 32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic drive(input logic r, input logic s, input logic [IW-1:0] a,
                       input logic h, input logic ab);
    reset = r; start = s; start_addr = a; halt_i = h; abort = ab;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check_eq({tag, "_core_en"}, 32'(core_en), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
    check_eq({tag, "_cnt"}, 32'(cycle_count), 32'd0);
    check_eq({tag, "_pc"}, 32'(pc_init), 32'd0);
  endtask

  // Start a run and walk through INIT; leaves the DUT in its first RUN cycle.
  task automatic launch(input logic [IW-1:0] a);
    drive(1'b0, 1'b1, a, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (RST_CYC) step();
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    check_reset_vals("rst");

    // Normal run, halt on 5th RUN cycle.
    drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    step();
    check_eq("norm_init_core_reset", 32'(core_reset), 32'd1);
    check_eq("norm_pc_init", 32'(pc_init), 32'h10);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    check_eq("norm_init2_core_reset", 32'(core_reset), 32'd1);
    step();
    check_eq("norm_run_core_reset", 32'(core_reset), 32'd0);
    check_eq("norm_run_core_en", 32'(core_en), 32'd1);
    repeat (4) step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check_eq("norm_done", 32'(done), 32'd1);
    check_eq("norm_timeout", 32'(timeout), 32'd0);
    check_eq("norm_cnt", 32'(cycle_count), 32'd5);
    check_eq("norm_core_en", 32'(core_en), 32'd0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step();
    check_eq("done_hold", 32'(done), 32'd1);
    check_eq("done_hold_cnt", 32'(cycle_count), 32'd5);

    // Restart from DONE, mid-run start ignored, then budget timeout.
    drive(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    step();
    check_eq("restart_busy", 32'(busy), 32'd1);
    check_eq("restart_cnt", 32'(cycle_count), 32'd0);
    check_eq("restart_pc", 32'(pc_init), 32'h40);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (RST_CYC) step();
    step();
    drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step();
    check_eq("ignore_start_pc", 32'(pc_init), 32'h40);
    repeat (16) step();
    check_eq("to_pre_busy", 32'(busy), 32'd1);
    check_eq("to_pre_cnt", 32'(cycle_count), 32'd19);
    step();
    check_eq("to_done", 32'(done), 32'd1);
    check_eq("to_timeout", 32'(timeout), 32'd1);
    check_eq("to_cnt", 32'(cycle_count), 32'd20);

    // Halt coinciding with budget exhaustion: halt wins.
    launch(8'h20);
    check_eq("sim_timeout_cleared", 32'(timeout), 32'd0);
    repeat (19) step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check_eq("sim_done", 32'(done), 32'd1);
    check_eq("sim_timeout", 32'(timeout), 32'd0);
    check_eq("sim_cnt", 32'(cycle_count), 32'd20);

    // Abort with halt on RUN cycle 3.
    launch(8'h21);
    repeat (2) step();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step();
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_core_reset", 32'(core_reset), 32'd1);
    check_eq("abort_cnt", 32'(cycle_count), 32'd3);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step();
    check_eq("abort_freeze_cnt", 32'(cycle_count), 32'd3);

    // Reset on RUN cycle 7 with start held.
    launch(8'h33);
    repeat (6) step();
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    step();
    check_reset_vals("midrst");

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
            IW'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter IW, default 8, sets the program-counter width.
REQ-002 Parameter CW, default 16, sets the cycle-counter width.
REQ-003 Parameter RST_CYC, default 2, sets the number of cycles core_reset is held in INIT; legal range 1..15.
REQ-004 Parameter MAX_CYC, default 1000, sets the RUN-cycle budget before timeout; legal range 1..2^CW-1.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high; clears the block on the next rising edge.
REQ-007 start  in  1  request to begin a program run; sampled each cycle.
REQ-008 start_addr  in  IW  initial PC for the run; sampled with start.
REQ-009 halt_i  in  1  Halt control bit from the core decoder.
REQ-010 abort  in  1  request to stop a run in progress.
REQ-011 core_reset  out  1  reset to the core datapath (PC, flags, CMP).
REQ-012 core_en  out  1  enable for PC advance and register/memory writes.
REQ-013 pc_init  out  IW  PC value the fetch unit loads while core_reset=1.
REQ-014 busy  out  1  high in INIT and RUN.
REQ-015 done  out  1  high in DONE.
REQ-016 timeout  out  1  high in DONE when the run ended on budget exhaustion.
REQ-017 cycle_count  out  CW  number of RUN cycles in the current or last run.

Function
REQ-018 The FSM SHALL have four states: IDLE, INIT, RUN and DONE.
REQ-019 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.
REQ-020 Output decode per state:
- core_reset = 1 in IDLE and INIT, 0 in RUN and DONE.
- core_en = 1 only in RUN.
- busy = 1 in INIT and RUN.
- done = 1 only in DONE.
REQ-021 IDLE with start=1: next state INIT; latch pc_init<=start_addr; clear cycle_count to 0; clear timeout to 0; load the INIT counter with RST_CYC.
REQ-022 IDLE with start=0: remain in IDLE; halt_i and abort are ignored.
REQ-023 INIT: decrement the INIT counter each cycle; enter RUN on the cycle the counter reaches 0, so core_reset is high for exactly RST_CYC cycles after IDLE.
REQ-024 start is ignored in INIT and RUN; pc_init stays stable.
REQ-025 RUN: cycle_count increments by 1 every RUN cycle, including the exit cycle.
REQ-026 RUN with halt_i=1: next state DONE; timeout stays 0.
REQ-027 RUN with halt_i=0 and the incremented count equal to MAX_CYC: next state DONE; timeout<=1.
REQ-028 Priority when halt_i and budget exhaustion occur in the same cycle: halt wins and timeout stays 0.
REQ-029 abort=1 in INIT or RUN: next state IDLE; cycle_count freezes; timeout stays 0; abort has priority over halt_i.
REQ-030 abort=1 in IDLE or DONE has no effect.
REQ-031 DONE: hold done, timeout, cycle_count and pc_init.
REQ-032 DONE with start=1: behave as IDLE with start=1 (direct restart into INIT, relatching start_addr).
REQ-033 cycle_count SHALL never wrap, since MAX_CYC is at most 2^CW-1.
REQ-034 halt_i is sampled only in RUN.

Reset
REQ-035 reset=1 SHALL force, on the next rising edge, from any state including mid-RUN:
- state IDLE, INIT counter 0;
- core_reset=1, core_en=0, busy=0, done=0, timeout=0;
- cycle_count=0, pc_init=0.
REQ-036 reset SHALL have priority over start, abort and halt_i.

Verification
REQ-037 Normal run: defaults, start=1 with start_addr=8'h10 in IDLE -> core_reset high 2 cycles, pc_init=8'h10; halt_i pulsed on the 5th RUN cycle -> done=1, timeout=0, cycle_count=5, core_en=0.
REQ-038 Timeout: MAX_CYC=20, halt_i never asserted -> DONE after exactly 20 RUN cycles, timeout=1, cycle_count=20.
REQ-039 Simultaneous exit: MAX_CYC=20, halt_i=1 on the 20th RUN cycle -> done=1, timeout=0, cycle_count=20.
REQ-040 Abort: abort=1 on RUN cycle 3 with halt_i=1 in the same cycle -> IDLE, done=0, core_reset=1, cycle_count=3.
REQ-041 Restart and ignore: in DONE, start=1 with start_addr=8'h40 -> INIT, cycle_count=0, pc_init=8'h40; a start pulse mid-RUN with start_addr=8'h55 -> pc_init remains 8'h40.
REQ-042 Reset mid-run: reset=1 on RUN cycle 7 -> all outputs at REQ-035 values next edge; start ignored while reset=1.
